// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline stage register.
// The optional skid entry is enabled by defining PIPE_STAGE_SKID_EN.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_t;

   typedef logic [1:0] pipe_occ_t;

   // Fill bit for an emptied or squashed entry.
   localparam logic PIPE_BUBBLE = 1'b0;

endpackage

// File: rtl/pipe_slot.sv
// One payload register with load/clear and a valid flag. Clear wins over
// load so a squashed entry always returns to the zero bubble.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             valid
);

   // Payload and valid flag; emptied entries hold the bubble value.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         q     <= {WIDTH{PIPE_BUBBLE}};
         valid <= 1'b0;
      end else if (clear) begin
         q     <= {WIDTH{PIPE_BUBBLE}};
         valid <= 1'b0;
      end else if (load) begin
         q     <= d;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with synchronous flush and a
// saturating backpressure counter. Define PIPE_STAGE_SKID_EN for the
// two-entry skid variant with a registered in_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   pipe_state_t      state, state_next;
   logic             main_load, main_clear, main_valid;
   logic [WIDTH-1:0] main_d;

   // Stage FSM state register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= EMPTY;
      else       state <= state_next;
   end

`ifdef PIPE_STAGE_SKID_EN
   logic             skid_load, skid_clear, skid_valid, main_from_skid;
   logic [WIDTH-1:0] skid_q;
   logic             in_ready_q;

   // Next state and slot controls for the two-entry skid buffer.
   always_comb begin
      state_next     = state;
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      if (flush) begin
         state_next = EMPTY;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (in_valid) begin
                  main_load  = 1'b1;
                  state_next = ONE;
               end
            end
            ONE: begin
               if (in_valid && out_ready) begin
                  main_load = 1'b1;
               end else if (out_ready) begin
                  main_clear = 1'b1;
                  state_next = EMPTY;
               end else if (in_valid) begin
                  skid_load  = 1'b1;
                  state_next = TWO;
               end
            end
            TWO: begin
               if (out_ready) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clear     = 1'b1;
                  state_next     = ONE;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   // Upstream ready comes straight from a flop, looking one state ahead.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) in_ready_q <= 1'b1;
      else       in_ready_q <= (state_next != TWO);
   end

   pipe_slot #(.WIDTH(WIDTH)) u_skid (
      .CLK   (CLK),
      .nRST  (nRST),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (in_data),
      .q     (skid_q),
      .valid (skid_valid)
   );

   assign main_d    = main_from_skid ? skid_q : in_data;
   assign in_ready  = in_ready_q;
   // Main is filled first and drained last, so the valid flags encode the state.
   assign occupancy = {skid_valid, main_valid & ~skid_valid};
`else
   // Next state and slot controls for the single-entry stage.
   always_comb begin
      state_next = state;
      main_load  = 1'b0;
      main_clear = 1'b0;
      if (flush) begin
         state_next = EMPTY;
         main_clear = 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (in_valid) begin
                  main_load  = 1'b1;
                  state_next = ONE;
               end
            end
            ONE: begin
               if (out_ready) begin
                  if (in_valid) begin
                     main_load = 1'b1;
                  end else begin
                     main_clear = 1'b1;
                     state_next = EMPTY;
                  end
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   assign main_d    = in_data;
   assign in_ready  = !main_valid || out_ready;
   assign occupancy = {1'b0, main_valid};
`endif

   pipe_slot #(.WIDTH(WIDTH)) u_main (
      .CLK   (CLK),
      .nRST  (nRST),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .q     (out_data),
      .valid (main_valid)
   );

   assign out_valid = main_valid;

   // Saturating count of cycles where downstream holds off a valid payload.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && stall_cnt != CNT_MAX)
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (WIDTH=8, CNT_W=4) against a
// queue-based model of the stage. Honours PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
   localparam int CAP  = 2;
`else
   localparam bit SKID = 1'b0;
   localparam int CAP  = 1;
`endif

   logic       CLK = 1'b0;
   logic       nRST = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready, out_valid;
   logic [7:0] out_data;
   logic [1:0] occupancy;
   logic [3:0] stall_cnt;

   pipe_stage_reg #(.WIDTH(8), .CNT_W(4)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt)
   );

   always #5 CLK = ~CLK;

   // {out_valid, out_data, occupancy, in_ready, stall_cnt}
   logic [15:0] obs;
   assign obs = {out_valid, out_data, occupancy, in_ready, stall_cnt};

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [7:0]  mq[$];
   int unsigned m_stall = 0;
   logic        exp_ready;
   logic [15:0] expv;

   // Apply inputs for this cycle and derive the expected outputs from the model.
   task automatic set_in(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
      logic [7:0] ed;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      #1;
      ed        = (mq.size() > 0) ? mq[0] : 8'h00;
      exp_ready = SKID ? (mq.size() < 2) : (mq.size() == 0 || ordy);
      expv      = {mq.size() > 0, ed, 2'(mq.size()), exp_ready, 4'(m_stall)};
   endtask

   // Update the model with this cycle's handshakes and move past the edge.
   task automatic advance();
      logic del, acc;
      del = (mq.size() > 0) && out_ready;
      acc = in_valid && exp_ready && !flush;
      if (mq.size() > 0 && !out_ready && m_stall < 15) m_stall++;
      if (del) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (acc) mq.push_back(in_data);
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b0, 8'h00, 1'b0, 1'b0);
         n_cmp++;
         if (obs !== 16'h0010) begin
            n_bad++;
            $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs, 16'h0010);
         end
         advance();
      end
   endtask

   task automatic test_stream();
      logic [7:0] vals[3] = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 4; i++) begin
         set_in(i < 3, (i < 3) ? vals[i] : 8'h00, 1'b1, 1'b0);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++;
            $display("FAIL stream cyc=%0d got=%h exp=%h", i, obs, expv);
         end
         if (i > 0) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== vals[i-1] || occupancy !== 2'd1) begin
               n_bad++;
               $display("FAIL stream_data cyc=%0d got=%b/%h/%0d exp=1/%h/1",
                        i, out_valid, out_data, occupancy, vals[i-1]);
            end
         end
         advance();
      end
      set_in(1'b0, 8'h00, 1'b1, 1'b0);
      advance();
   endtask

   task automatic test_backpressure();
      logic [7:0] want[3] = '{8'hA5, 8'hA5, 8'h5A};
      set_in(1'b1, 8'hA5, 1'b0, 1'b0);
      advance();
      set_in(1'b1, 8'h5A, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL bp_hold got=%h exp=%h", obs, expv);
      end
      advance();
      // Skid stage has taken 0x5A already; single stage still offers it.
      set_in(!SKID, 8'h5A, 1'b0, 1'b0);
      n_cmp++;
      if (occupancy !== 2'(CAP) || in_ready !== 1'b0 || obs !== expv) begin
         n_bad++;
         $display("FAIL bp_full got=%h occ=%0d rdy=%b exp=%h occ=%0d rdy=0",
                  obs, occupancy, in_ready, expv, CAP);
      end
      advance();
      for (int i = 0; i < 3; i++) begin
         set_in((!SKID) && i == 0, 8'h5A, 1'b1, 1'b0);
         n_cmp++;
         if (obs !== expv || (i < 2 && (out_valid !== 1'b1 || out_data !== want[i+1]))
             || (i == 2 && out_valid !== 1'b0)) begin
            n_bad++;
            $display("FAIL bp_drain cyc=%0d got=%h exp=%h", i, obs, expv);
         end
         advance();
      end
   endtask

   task automatic test_flush();
      set_in(1'b1, 8'hA1, 1'b0, 1'b0);
      advance();
      if (SKID) begin
         set_in(1'b1, 8'hB2, 1'b0, 1'b0);
         advance();
      end
      set_in(1'b1, 8'hFF, 1'b0, 1'b1);
      n_cmp++;
      if (obs !== expv || occupancy !== 2'(CAP)) begin
         n_bad++;
         $display("FAIL flush_pre got=%h exp=%h", obs, expv);
      end
      advance();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b0, 8'h00, 1'b1, 1'b0);
         n_cmp++;
         if (obs !== expv || occupancy !== 2'd0 || out_data !== 8'h00 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_post cyc=%0d got=%h exp=%h", i, obs, expv);
         end
         advance();
      end
      // Flush with a new input while empty: stays empty and ready.
      set_in(1'b1, 8'h3C, 1'b0, 1'b1);
      advance();
      set_in(1'b0, 8'h00, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== expv || occupancy !== 2'd0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL flush_empty got=%h exp=%h", obs, expv);
      end
      advance();
   endtask

   task automatic test_stall_sat();
      set_in(1'b1, 8'h77, 1'b0, 1'b0);
      advance();
      for (int i = 0; i < 20; i++) begin
         set_in(1'b0, 8'h00, 1'b0, 1'b0);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++;
            $display("FAIL stall_run cyc=%0d got=%h exp=%h", i, obs, expv);
         end
         advance();
      end
      set_in(1'b0, 8'h00, 1'b0, 1'b1);
      n_cmp++;
      if (stall_cnt !== 4'hF) begin
         n_bad++;
         $display("FAIL stall_sat got=%0d exp=15", stall_cnt);
      end
      advance();
      set_in(1'b0, 8'h00, 1'b0, 1'b0);
      n_cmp++;
      if (stall_cnt !== 4'hF || obs !== expv) begin
         n_bad++;
         $display("FAIL stall_after_flush got=%h exp=%h", obs, expv);
      end
      advance();
   endtask

   task automatic test_async_reset();
      set_in(1'b1, 8'hC1, 1'b0, 1'b0);
      advance();
      set_in(1'b1, 8'hC2, 1'b0, 1'b0);
      advance();
      #2;
      nRST = 1'b0;
      #1;
      n_cmp++;
      if (obs !== 16'h0010) begin
         n_bad++;
         $display("FAIL async_reset got=%h exp=%h", obs, 16'h0010);
      end
      mq.delete();
      m_stall = 0;
      in_valid = 1'b0;
      @(posedge CLK);
      #3;
      nRST = 1'b1;
      @(posedge CLK);
      #1;
      for (int i = 0; i < 4; i++) begin
         set_in(i == 0, 8'hD4, 1'b1, 1'b0);
         n_cmp++;
         if (obs !== expv || (out_valid === 1'b1 && out_data !== 8'hD4)) begin
            n_bad++;
            $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, obs, expv);
         end
         advance();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 250; i++) begin
         set_in($urandom_range(9, 0) < 7, 8'($urandom), $urandom_range(9, 0) < 6,
                $urandom_range(15, 0) == 0);
         n_cmp++;
         if (obs !== expv) begin
            n_bad++;
            $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, expv);
         end
         advance();
      end
   endtask

   initial begin
      #12;
      nRST = 1'b1;
      @(posedge CLK);
      #1;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_stall_sat();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule
